fdivsqrt_sched: RTL and testbench
=================================

# fdivsqrt_sched

Scheduler that shares the single iterative divide/square-root unit between two requesters (port 0: FPU issue, port 1: secondary/microcode port). It arbitrates round-robin, sequences the unit's start/done handshake, steers operand selection, returns a tagged response, and aborts in-flight operations on flush. It sits between the FPU issue logic and the divide/sqrt datapath plus its control FSM.

## Interface
- TAG_W, 3, width of requester tag returned with the response
- WDOG_CYCLES, 40, watchdog limit in cycles (used only with the watchdog macro)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req0_valid / req1_valid  in  1  operation request per port
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  1  0 = divide, 1 = sqrt
- req0_tag / req1_tag  in  TAG_W  requester tag
- flush0 / flush1  in  1  kill any accepted or in-flight op owned by that port
- du_start  out  1  one-cycle start pulse to the unit
- du_op_type  out  1  op type to the unit; valid while du_start is high
- du_sel  out  1  operand-source mux select (owning port), held from grant to idle
- du_reset  out  1  one-cycle abort pulse, ORed with the unit's reset
- du_done  in  1  unit completion pulse
- du_error  in  1  unit exception flag, sampled with du_done
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_id  out  1  owning port
- rsp_tag  out  TAG_W  owning tag
- rsp_err  out  1  unit error or watchdog timeout
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, START, WAIT, RESP, ABORT.
- IDLE: a port is eligible when reqN_valid=1 and flushN=0. One eligible port is granted; with two, the port named by the priority pointer is granted. reqN_ready=1 only for the granted port, combinationally, in IDLE. The grant latches op, tag and id, and du_sel=id. Next state: START.
- START: du_start=1, du_op_type=latched op. Next state: WAIT, unconditionally.
- WAIT: a flush of the owner goes to ABORT. Otherwise, du_done=1 latches rsp_err=du_error and goes to RESP. Flush and du_done in the same cycle: flush wins.
- RESP: rsp_valid=1 until rsp_valid&rsp_ready, then IDLE. A flush of the owner drops the response (no handshake) and goes to IDLE.
- ABORT: du_reset=1 for one cycle. Next state: IDLE. No response is produced.
- Priority pointer: after each grant it points to the non-granted port. Reset value is 0.
- rsp_id, rsp_tag and du_sel stay stable from grant until the return to IDLE.

## Timing
- Reset values: state IDLE, all outputs 0, priority pointer 0, latched fields 0.
- If the grant is in cycle N, du_start is high in N+1.
- rsp_valid rises the cycle after du_done is sampled.
- Best-case back-to-back issue: the next grant comes the cycle after the response handshake.
- reqN_ready never depends on rsp_ready.
- Reset in any state returns to IDLE on the next edge. du_reset is not pulsed, because the unit shares reset.

## Configuration
- FDIVSQRT_WATCHDOG_EN defined:
  - A 6-bit counter clears on entry to WAIT and increments each cycle in WAIT.
  - When it reaches WDOG_CYCLES without du_done, du_reset pulses that cycle, rsp_err=1, and the next state is RESP.
  - du_done in that same cycle takes priority over the timeout.
- Undefined: no counter; WAIT is held indefinitely.

## Structure
- Shared package fdivsqrt_pkg holds:
  - the state enum
  - OP_DIV=1'b0 and OP_SQRT=1'b1
  - port id constants
- Sub-module rr_arb2: two-input round-robin arbiter with eligibility inputs, a grant vector and pointer update on an accept strobe.

## Test plan
- req0_valid, op=1, tag=5, unit done 22 cycles after start -> du_start in the cycle after grant; rsp_valid the cycle after done; rsp_id=0, rsp_tag=5, rsp_err=0.
- req0 and req1 valid together from reset -> port 0 granted first, port 1 next; a second simultaneous pair -> port 1 first.
- flush0 three cycles into WAIT -> du_reset one pulse, no rsp_valid, IDLE the next cycle, req1 granted the following cycle.
- du_done with du_error=1 and rsp_ready held low for 4 cycles -> rsp_valid, tag and err held steady; flush0 in the 3rd cycle drops the response.
- flush0 and du_done in the same cycle -> ABORT, no response.
- Watchdog enabled, WDOG_CYCLES=40, du_done never asserted -> du_reset at cycle 40 of WAIT, then rsp_valid with rsp_err=1.

Source files
------------

// File: rtl/fdivsqrt_pkg.sv
// Shared definitions for the divide/sqrt scheduler: FSM states,
// op encodings and requester port ids.
package fdivsqrt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RESP,
    ST_ABORT
  } sched_state_e;

  localparam logic OP_DIV  = 1'b0;
  localparam logic OP_SQRT = 1'b1;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/fdivsqrt_sched_if.sv
// Bundle of request, unit-handshake and response signals around the
// divide/sqrt scheduler. slave = scheduler view, master = surroundings.
interface fdivsqrt_sched_if #(
  parameter int TAG_W = 3
) ();

  logic             req0_valid;
  logic             req0_ready;
  logic             req0_op;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid;
  logic             req1_ready;
  logic             req1_op;
  logic [TAG_W-1:0] req1_tag;
  logic             flush0;
  logic             flush1;

  logic             du_start;
  logic             du_op_type;
  logic             du_sel;
  logic             du_reset;
  logic             du_done;
  logic             du_error;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_tag,
    input  req1_valid, req1_op, req1_tag,
    input  flush0, flush1,
    input  du_done, du_error,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output du_start, du_op_type, du_sel, du_reset,
    output rsp_valid, rsp_id, rsp_tag, rsp_err,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_tag,
    output req1_valid, req1_op, req1_tag,
    output flush0, flush1,
    output du_done, du_error,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  du_start, du_op_type, du_sel, du_reset,
    input  rsp_valid, rsp_id, rsp_tag, rsp_err,
    input  busy
  );

endinterface

// File: rtl/fdivsqrt_sched_rr_arb2.sv
// Two-input round-robin arbiter. With both inputs eligible the port named
// by the pointer wins; on accept the pointer moves to the losing port.
module rr_arb2
  import fdivsqrt_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] elig,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr;

  // Grant selection: single requester wins outright, pointer breaks ties
  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = (ptr == PORT1) ? 2'b10 : 2'b01;
    end
  end

  // Pointer update: after a grant, favour the port that was not granted
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= PORT0;
    end else if (accept && (grant != '0)) begin
      ptr <= grant[0] ? PORT1 : PORT0;
    end
  end

endmodule

// File: rtl/fdivsqrt_sched.sv
// Scheduler sharing one iterative divide/sqrt unit between two requesters.
// Optional feature macro: FDIVSQRT_WATCHDOG_EN (WAIT-state timeout).
module fdivsqrt_sched
  import fdivsqrt_pkg::*;
#(
  parameter int TAG_W       = 3,
  parameter int WDOG_CYCLES = 40
) (
  input logic             clk,
  input logic             reset,
  fdivsqrt_sched_if.slave bus
);

  sched_state_e     state;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic             accept;
  logic             gnt_id;
  logic             gnt_op;
  logic [TAG_W-1:0] gnt_tag;
  logic             owner_flush;
  logic             wdog_hit;

  logic             du_start_q;
  logic             du_op_q;
  logic             du_reset_q;
  logic             owner_q;
  logic             rsp_valid_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_err_q;
  logic             busy_q;

  assign elig = {bus.req1_valid & ~bus.flush1, bus.req0_valid & ~bus.flush0};

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .elig   (elig),
    .accept (accept),
    .grant  (grant)
  );

  assign accept  = (state == ST_IDLE) && (grant != '0);
  assign gnt_id  = grant[1] ? PORT1 : PORT0;
  assign gnt_op  = (gnt_id == PORT1) ? bus.req1_op : bus.req0_op;
  assign gnt_tag = (gnt_id == PORT1) ? bus.req1_tag : bus.req0_tag;

  assign owner_flush = (owner_q == PORT1) ? bus.flush1 : bus.flush0;

  assign bus.req0_ready = (state == ST_IDLE) && grant[0];
  assign bus.req1_ready = (state == ST_IDLE) && grant[1];
  assign bus.du_start   = du_start_q;
  assign bus.du_op_type = du_op_q;
  assign bus.du_sel     = owner_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = owner_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = busy_q;

`ifdef FDIVSQRT_WATCHDOG_EN
  logic [5:0] wdog_cnt;

  // Watchdog counter: cleared while entering WAIT, counts WAIT cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt <= '0;
    end else if (state == ST_START) begin
      wdog_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wdog_cnt <= wdog_cnt + 6'd1;
    end
  end

  assign wdog_hit = (state == ST_WAIT) && (wdog_cnt == 6'(WDOG_CYCLES - 1));
  // The timeout abort must hit the unit in the expiry cycle itself, so it is
  // ORed in combinationally; flush and du_done in that cycle suppress it.
  assign bus.du_reset = du_reset_q | (wdog_hit & ~bus.du_done & ~owner_flush);
`else
  // Timeout compiled out: WAIT is held until du_done or a flush
  assign wdog_hit     = (WDOG_CYCLES < 0);
  assign bus.du_reset = du_reset_q;
`endif

  // Control FSM with registered unit and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      du_start_q  <= 1'b0;
      du_op_q     <= OP_DIV;
      du_reset_q  <= 1'b0;
      owner_q     <= PORT0;
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      du_start_q <= 1'b0;
      du_reset_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_START;
            du_start_q <= 1'b1;
            du_op_q    <= gnt_op;
            owner_q    <= gnt_id;
            rsp_tag_q  <= gnt_tag;
            busy_q     <= 1'b1;
          end
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (owner_flush) begin
            state      <= ST_ABORT;
            du_reset_q <= 1'b1;
          end else if (bus.du_done) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus.du_error;
          end else if (wdog_hit) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end
        end
        ST_RESP: begin
          if (owner_flush || bus.rsp_ready) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        ST_ABORT: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fdivsqrt_sched.sv
// Self-checking bench for fdivsqrt_sched: responses are scoreboarded,
// handshake timing and abort behaviour are checked inline per scenario.
module tb_fdivsqrt_sched;

  localparam int TAG_W = 3;

  typedef struct packed {
    logic             id;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  fdivsqrt_sched_if #(.TAG_W(TAG_W)) bus ();

  fdivsqrt_sched #(
    .TAG_W       (TAG_W),
    .WDOG_CYCLES (40)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Response monitor: every handshake must match the oldest expected entry
  always @(negedge clk) begin
    rsp_t got;
    rsp_t want;
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      got = '{bus.rsp_id, bus.rsp_tag, bus.rsp_err};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got=%h required=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL rsp_scoreboard got=%h required=%h", got, want);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 1'b0; bus.req0_op = 1'b0; bus.req0_tag = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 1'b0; bus.req1_tag = '0;
    bus.flush0 = 1'b0; bus.flush1 = 1'b0;
    bus.du_done = 1'b0; bus.du_error = 1'b0; bus.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Starting in the START cycle: unit finishes after lat WAIT cycles,
  // response is accepted immediately; ends in the following IDLE cycle.
  task automatic finish_op(input int lat, input logic err);
    tick();
    repeat (lat - 1) tick();
    bus.du_done = 1'b1; bus.du_error = err;
    tick();
    bus.du_done = 1'b0; bus.du_error = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] outs;
    do_reset();
    outs = {bus.busy, bus.du_start, bus.du_reset, bus.rsp_valid, bus.du_sel,
            bus.rsp_id, bus.rsp_err, bus.du_op_type, bus.rsp_tag};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs got=%b required=0", outs);
    end
    // reset taken mid-operation returns to IDLE without an abort pulse
    bus.req1_valid = 1'b1; bus.req1_op = 1'b1; bus.req1_tag = 3'd6;
    tick(); bus.req1_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.busy, bus.du_reset, bus.du_start} !== 3'b000) begin
      errors++; $display("FAIL reset_midop got=%b required=000", {bus.busy, bus.du_reset, bus.du_start});
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_op = 1'b1; bus.req0_tag = 3'd5;
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++; $display("FAIL single_ready got=%b required=01", {bus.req1_ready, bus.req0_ready});
    end
    exp_q.push_back('{1'b0, 3'd5, 1'b0});
    tick();
    bus.req0_valid = 1'b0;
    checks++;
    if ({bus.du_start, bus.du_op_type, bus.du_sel, bus.busy} !== 4'b1101) begin
      errors++; $display("FAIL single_start got=%b required=1101", {bus.du_start, bus.du_op_type, bus.du_sel, bus.busy});
    end
    tick();
    checks++;
    if (bus.du_start !== 1'b0) begin
      errors++; $display("FAIL single_start_pulse got=%b required=0", bus.du_start);
    end
    for (int i = 0; i < 21; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++; $display("FAIL single_wait_idle cyc=%0d got=%b required=0", i, bus.rsp_valid);
      end
      tick();
    end
    bus.du_done = 1'b1;
    tick();
    bus.du_done = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_err} !== {1'b1, 1'b0, 3'd5, 1'b0}) begin
      errors++; $display("FAIL single_rsp got=%b required=1_0_101_0", {bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_err});
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL single_idle got=%b required=00", {bus.rsp_valid, bus.busy});
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_op = 1'b0; bus.req0_tag = 3'd1;
    bus.req1_valid = 1'b1; bus.req1_op = 1'b1; bus.req1_tag = 3'd2;
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++; $display("FAIL rr_first got=%b required=01", {bus.req1_ready, bus.req0_ready});
    end
    exp_q.push_back('{1'b0, 3'd1, 1'b0});
    tick();
    bus.req0_valid = 1'b0;
    finish_op(3, 1'b0);
    bus.req0_valid = 1'b1; bus.req0_tag = 3'd3;
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
      errors++; $display("FAIL rr_second_pair got=%b required=10", {bus.req1_ready, bus.req0_ready});
    end
    exp_q.push_back('{1'b1, 3'd2, 1'b0});
    tick();
    bus.req1_valid = 1'b0;
    checks++;
    if ({bus.du_sel, bus.du_op_type} !== 2'b11) begin
      errors++; $display("FAIL rr_sel1 got=%b required=11", {bus.du_sel, bus.du_op_type});
    end
    finish_op(2, 1'b0);
    #1;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++; $display("FAIL rr_third got=%b required=01", {bus.req1_ready, bus.req0_ready});
    end
    exp_q.push_back('{1'b0, 3'd3, 1'b0});
    tick();
    bus.req0_valid = 1'b0;
    finish_op(1, 1'b0);
  endtask

  task automatic test_flush_wait();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_tag = 3'd4;
    bus.req1_valid = 1'b1; bus.req1_tag = 3'd7; bus.req1_op = 1'b0;
    tick();
    bus.req0_valid = 1'b0;
    repeat (3) tick();
    bus.flush0 = 1'b1;
    tick();
    bus.flush0 = 1'b0;
    #1;
    checks++;
    if ({bus.du_reset, bus.rsp_valid, bus.busy, bus.req1_ready} !== 4'b1010) begin
      errors++; $display("FAIL flush_abort got=%b required=1010", {bus.du_reset, bus.rsp_valid, bus.busy, bus.req1_ready});
    end
    tick();
    #1;
    checks++;
    if ({bus.du_reset, bus.busy, bus.rsp_valid, bus.req1_ready} !== 4'b0001) begin
      errors++; $display("FAIL flush_regrant got=%b required=0001", {bus.du_reset, bus.busy, bus.rsp_valid, bus.req1_ready});
    end
    exp_q.push_back('{1'b1, 3'd7, 1'b0});
    tick();
    bus.req1_valid = 1'b0;
    checks++;
    if ({bus.du_start, bus.du_sel} !== 2'b11) begin
      errors++; $display("FAIL flush_next_start got=%b required=11", {bus.du_start, bus.du_sel});
    end
    finish_op(4, 1'b0);
  endtask

  task automatic test_err_hold();
    bus.req0_valid = 1'b1; bus.req0_op = 1'b0; bus.req0_tag = 3'd6;
    tick();
    bus.req0_valid = 1'b0;
    checks++;
    if ({bus.du_start, bus.du_op_type, bus.du_sel} !== 3'b100) begin
      errors++; $display("FAIL err_start got=%b required=100", {bus.du_start, bus.du_op_type, bus.du_sel});
    end
    repeat (5) tick();
    bus.du_done = 1'b1; bus.du_error = 1'b1;
    tick();
    bus.du_done = 1'b0; bus.du_error = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_err} !== {1'b1, 1'b0, 3'd6, 1'b1}) begin
        errors++; $display("FAIL err_hold cyc=%0d got=%b required=1_0_110_1", i, {bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_err});
      end
      if (i == 3) bus.flush0 = 1'b1;
      tick();
    end
    bus.flush0 = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL err_dropped got=%b required=00", {bus.rsp_valid, bus.busy});
    end
  endtask

  task automatic test_flush_vs_done();
    bus.req0_valid = 1'b1; bus.req0_tag = 3'd2;
    tick();
    bus.req0_valid = 1'b0;
    repeat (2) tick();
    bus.du_done = 1'b1; bus.flush0 = 1'b1;
    tick();
    bus.du_done = 1'b0; bus.flush0 = 1'b0;
    checks++;
    if ({bus.du_reset, bus.rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL flushdone_abort got=%b required=10", {bus.du_reset, bus.rsp_valid});
    end
    tick();
    checks++;
    if ({bus.du_reset, bus.rsp_valid, bus.busy} !== 3'b000) begin
      errors++; $display("FAIL flushdone_idle got=%b required=000", {bus.du_reset, bus.rsp_valid, bus.busy});
    end
  endtask

  task automatic test_back_to_back();
    bus.req1_valid = 1'b1; bus.req1_op = 1'b1; bus.req1_tag = 3'd3;
    exp_q.push_back('{1'b1, 3'd3, 1'b0});
    tick();
    tick();
    #1;
    checks++;
    if (bus.req1_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_busy_ready got=%b required=0", bus.req1_ready);
    end
    bus.du_done = 1'b1;
    tick();
    bus.du_done = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.req1_ready} !== 2'b10) begin
      errors++; $display("FAIL b2b_resp got=%b required=10", {bus.rsp_valid, bus.req1_ready});
    end
    tick();
    bus.rsp_ready = 1'b0;
    bus.req1_tag = 3'd4;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_regrant got=%b required=1", bus.req1_ready);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready_indep got=%b required=1", bus.req1_ready);
    end
    bus.rsp_ready = 1'b0;
    exp_q.push_back('{1'b1, 3'd4, 1'b0});
    tick();
    bus.req1_valid = 1'b0;
    checks++;
    if ({bus.du_start, bus.du_sel} !== 2'b11) begin
      errors++; $display("FAIL b2b_start got=%b required=11", {bus.du_start, bus.du_sel});
    end
    finish_op(2, 1'b0);
  endtask

`ifdef FDIVSQRT_WATCHDOG_EN
  task automatic test_watchdog();
    bus.req0_valid = 1'b1; bus.req0_tag = 3'd2;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    for (int i = 1; i < 40; i++) begin
      checks++;
      if ({bus.du_reset, bus.rsp_valid} !== 2'b00) begin
        errors++; $display("FAIL wdog_early cyc=%0d got=%b required=00", i, {bus.du_reset, bus.rsp_valid});
      end
      tick();
    end
    checks++;
    if ({bus.du_reset, bus.rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL wdog_fire got=%b required=10", {bus.du_reset, bus.rsp_valid});
    end
    exp_q.push_back('{1'b0, 3'd2, 1'b1});
    tick();
    checks++;
    if ({bus.du_reset, bus.rsp_valid, bus.rsp_err} !== 3'b011) begin
      errors++; $display("FAIL wdog_rsp got=%b required=011", {bus.du_reset, bus.rsp_valid, bus.rsp_err});
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_flush_wait();
    test_err_hold();
    test_flush_vs_done();
    test_back_to_back();
`ifdef FDIVSQRT_WATCHDOG_EN
    test_watchdog();
`endif
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
